// File: rtl/bit_stream_deserializer.sv
// bit_stream_deserializer: collects a serial bit stream into WIDTH-bit words behind a valid/ready port
module bit_stream_deserializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       CLK,
  input  logic                       ASYNCRESETN,
  input  logic                       I,
  input  logic                       I_valid,
  output logic                       I_ready,
  output logic [WIDTH-1:0]           O,
  output logic                       O_valid,
  input  logic                       O_ready,
  output logic [$clog2(WIDTH)-1:0]   count
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d, pos;
  logic [WIDTH-1:0] sr_q, sr_d, o_q, o_d;
  logic last, in_beat, out_beat;
  assign last = count_q == LAST;
  assign I_ready = ASYNCRESETN & ~(last & (state_q == FULL) & ~O_ready);
  assign in_beat = I_valid & I_ready;
  assign out_beat = (state_q == FULL) & O_ready;
  assign pos = MSB_FIRST ? LAST - count_q : count_q;
  assign O = o_q;
  assign O_valid = state_q == FULL;
  assign count = count_q;
  // Shift in the accepted bit; on the final bit hand the merged word to the output register
  always_comb begin
    sr_d = sr_q;
    count_d = count_q;
    o_d = o_q;
    state_d = state_q;
    if (in_beat) sr_d[pos] = I;
    if (in_beat && last) begin
      o_d = sr_d;
      sr_d = '0;
      count_d = '0;
      state_d = FULL;
    end else begin
      if (in_beat) count_d = count_q + 1'b1;
      if (out_beat) state_d = EMPTY;
    end
  end
  // State registers, cleared immediately by reset
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= EMPTY;
      count_q <= '0;
      sr_q <= '0;
      o_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sr_q <= sr_d;
      o_q <= o_d;
    end
  end
endmodule

// File: doc/bit_stream_deserializer.md
Name: bit_stream_deserializer

Overview:
Downstream consumer of the single-bit mux/select stage. It collects the selected bit stream (one bit per accepted cycle) into WIDTH-bit words and presents them on a valid/ready output port. The block is double-buffered: a shift register fills while the previous word is held on the output. Upstream stalls only when a word completes and the held word has not yet been taken.

Parameters:
WIDTH, 8, word width in bits; legal range 2..64.
MSB_FIRST, 0, bit order. 0 = first accepted bit lands in O[0]. 1 = first accepted bit lands in O[WIDTH-1].

Ports:
CLK  input  1  clock; all state updates on the rising edge.
ASYNCRESETN  input  1  asynchronous reset, active-low.
I  input  1  serial data bit (the upstream select stage's O).
I_valid  input  1  I carries a bit this cycle.
I_ready  output  1  the block accepts I this cycle.
O  output  WIDTH  assembled word.
O_valid  output  1  O holds an unconsumed word.
O_ready  input  1  downstream takes O this cycle.
count  output  clog2(WIDTH)  bits accepted into the current partial word.

Behaviour:
- Clock and reset: one clock, CLK. ASYNCRESETN is asynchronous and active-low.
- Reset (ASYNCRESETN=0) takes effect immediately, with no clock edge needed:
  - count=0, shift register=0, O=0, O_valid=0.
  - I_ready is forced 0 while reset is asserted.
  - Any partial word is discarded.
  - Normal operation resumes on the first CLK edge after deassertion.
- Output state machine has two states, equivalent to O_valid:
  - EMPTY (O_valid=0).
  - FULL (O_valid=1).
- Handshakes:
  - Input beat = I_valid & I_ready.
  - Output beat = O_valid & O_ready.
- I_ready = !(count==WIDTH-1 & O_valid & !O_ready).
  - Combinational from O_ready; no other combinational paths.
  - I_ready is 1 for all counts below WIDTH-1, whatever the output state.
- On an input beat with count < WIDTH-1:
  - The bit is written to position count (MSB_FIRST=0) or WIDTH-1-count (MSB_FIRST=1).
  - count increments by 1.
- On an input beat with count == WIDTH-1 (word completion):
  - O <= shift register contents merged with the final bit.
  - O_valid <= 1; count <= 0; shift register cleared.
- O_valid next-state rules:
  - Output beat with no completion: O_valid <= 0; O keeps its last value (don't-care to the consumer).
  - Output beat and completion in the same cycle: O_valid stays 1 and O takes the new word. No bubble, no loss.
  - No output beat while FULL: O and O_valid are held stable. They must not change while O_valid=1 & O_ready=0.
- Latency: a final bit accepted at edge t gives O_valid=1 and the new O after edge t.
- Throughput: one bit per cycle sustained when O_ready=1, i.e. a word every WIDTH cycles.
- I is ignored when I_valid=0. Idle cycles do not alter count or the shift register.
- count wraps WIDTH-1 -> 0 only on word completion; it never exceeds WIDTH-1.
- O_ready while EMPTY has no effect.

Test Plan:
1. WIDTH=8, MSB_FIRST=0, O_ready=1; stream bits 1,0,1,0,0,1,0,1 on consecutive cycles -> O_valid=1 for exactly one cycle after the 8th bit, O=0xA5, count back to 0.
2. Backpressure:
   - Send 0x3C with O_ready=0, then 7 bits of 0xFF -> I_ready stays 1 through those 7 bits.
   - With count=7, I_ready=0 and O holds 0x3C.
   - Raise O_ready in a cycle with I_valid=1 -> 8th bit accepted that cycle; next cycle O=0xFF, O_valid=1.
3. Gapped input: send 0x5A LSB-first with I_valid low for 3 random cycles between bits, I toggling during the gaps -> O=0x5A, count unaffected by the gaps.
4. Reset mid-word:
   - After 4 bits, pulse ASYNCRESETN low between clock edges -> O_valid=0 and count=0 immediately, before the next edge.
   - Then send 0x81 -> O=0x81.
5. MSB_FIRST=1; bits 0,0,0,1,0,0,1,0 -> O=0x12. The same sequence with MSB_FIRST=0 -> O=0x48.
6. Back-to-back: 16 continuous bits (0xC3 then 0x3C, LSB-first) with O_ready=1 -> words presented 8 cycles apart, I_ready never drops, O=0xC3 then O=0x3C.
